// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester-side byte streams and the UART TX write port.
// The arbiter uses the slave view; requesters and the UART model use the master view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_data_reg_wr;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 lock_timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data_reg_wr, tx_data, lock_timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data_reg_wr, tx_data, lock_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Ownership is held for a whole message (until req_last) so output never interleaves;
// an owner that stops presenting bytes is evicted after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int TO_W         = 11
) (
    input  logic              ACLK,
    input  logic              ARESET,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN,
        S_WRITE,
        S_GUARD,
        S_DRAIN
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [7:0]         tx_data_q;
    logic               wr_q;
    logic               lto_q;
    logic               last_q;
    logic [TO_W-1:0]    to_cnt;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic               owner_valid;
    logic [7:0]         owner_byte;

    // Index arithmetic modulo NUM_REQ, used for the search origin and pointer advance.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    assign owner_valid = bus.req_valid[owner];
    assign owner_byte  = bus.req_data[{owner, 3'b000} +: 8];

    // Pick the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // Only the owner ever sees ready, and only when the UART can take a byte.
    always_comb begin
        bus.req_ready = '0;
        if (state == S_OWN) begin
            bus.req_ready[owner] = owner_valid & ~bus.tx_busy;
        end
    end

    // Ownership FSM; all outputs except req_ready are registered here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            grant_q   <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            tx_data_q <= '0;
            wr_q      <= 1'b0;
            lto_q     <= 1'b0;
            last_q    <= 1'b0;
            to_cnt    <= '0;
        end else begin
            wr_q  <= 1'b0;
            lto_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q <= onehot(pick_idx);
                        owner   <= pick_idx;
                        to_cnt  <= '0;
                        state   <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (owner_valid) begin
                        // A busy UART stalls acceptance without aging the lock.
                        if (!bus.tx_busy) begin
                            tx_data_q <= owner_byte;
                            last_q    <= bus.req_last[owner];
                            wr_q      <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                        lto_q   <= 1'b1;
                        grant_q <= '0;
                        rr_ptr  <= wrap_add(owner, 1);
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WRITE: state <= S_GUARD;
                // The UART raises tx_busy one cycle after the strobe, so skip a cycle before looking.
                S_GUARD: state <= S_DRAIN;
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_ptr  <= wrap_add(owner, 1);
                            state   <= S_IDLE;
                        end else begin
                            to_cnt <= '0;
                            state  <= S_OWN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant          = grant_q;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_data_reg_wr = wr_q;
    assign bus.lock_timeout   = lto_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// multi-message run compared against a message-level round-robin reference.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 2;
    localparam int LT      = 16;
    localparam int TO_W    = 5;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .LOCK_TIMEOUT(LT),
        .TO_W        (TO_W)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus_if)
    );

    int n_total = 0;
    int n_fail  = 0;

    // Requester message queues and UART busy model state.
    logic [7:0] q_data[NUM_REQ][$];
    bit         q_last[NUM_REQ][$];
    logic [7:0] m_data[NUM_REQ][$];
    bit         m_last[NUM_REQ][$];
    bit         auto_drive;
    bit         rand_busy;
    int         busy_len;
    int         busy_cnt;

    // Values sampled at the falling edge.
    logic [NUM_REQ-1:0] s_ready, s_grant;
    logic               s_wr, s_lto;
    logic [7:0]         s_data;
    int                 s_cyc;

    // Everything written to the UART.
    logic [7:0]         log_data[$];
    logic [NUM_REQ-1:0] log_grant[$];
    int                 log_cyc[$];

    logic [7:0]         exp_data[$];
    logic [NUM_REQ-1:0] exp_grant[$];

    int cyc, inv_bad, lto_seen, ready_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input bit l);
        q_data[r].push_back(d);
        q_last[r].push_back(l);
    endtask

    task automatic apply_drive();
        if (auto_drive) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (q_data[i].size() > 0) begin
                    bus_if.req_valid[i]       = 1'b1;
                    bus_if.req_data[8*i +: 8] = q_data[i][0];
                    bus_if.req_last[i]        = q_last[i][0];
                end else begin
                    bus_if.req_valid[i]       = 1'b0;
                    bus_if.req_data[8*i +: 8] = 8'h00;
                    bus_if.req_last[i]        = 1'b0;
                end
            end
        end
    endtask

    // One clock: sample outputs mid-cycle, then update requesters and UART after the edge.
    task automatic tick();
        @(negedge ACLK);
        s_ready = bus_if.req_ready;
        s_grant = bus_if.grant;
        s_wr    = bus_if.tx_data_reg_wr;
        s_data  = bus_if.tx_data;
        s_lto   = bus_if.lock_timeout;
        s_cyc   = cyc;
        if ($countones(s_grant) > 1 || (s_ready & ~s_grant) != '0) inv_bad++;
        if (s_lto === 1'b1) lto_seen++;
        if (s_ready != '0) ready_seen++;
        if (s_wr === 1'b1) begin
            log_data.push_back(s_data);
            log_grant.push_back(s_grant);
            log_cyc.push_back(s_cyc);
        end
        @(posedge ACLK);
        #1;
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_ready[i] === 1'b1 && q_data[i].size() > 0) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
        if (busy_cnt > 0) busy_cnt--;
        if (s_wr === 1'b1) busy_cnt = rand_busy ? int'($urandom_range(0, 4)) : busy_len;
        bus_if.tx_busy = (busy_cnt > 0);
        apply_drive();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        auto_drive = 1'b0;
        rand_busy = 1'b0;
        busy_len = 0;
        busy_cnt = 0;
        bus_if.tx_busy   = 1'b0;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        tick();
        tick();
        ARESET = 1'b0;
        auto_drive = 1'b1;
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        lto_seen = 0;
        ready_seen = 0;
        cyc = 0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, log_data.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t_lto, p, idx, total, n_before;
        bit found;
        logic [7:0] b;
        bit l;

        cyc = 0;
        inv_bad = 0;
        lto_seen = 0;
        ready_seen = 0;
        auto_drive = 1'b0;
        rand_busy = 1'b0;
        busy_len = 0;
        busy_cnt = 0;

        // Reset held with both requesters asking.
        ARESET = 1'b1;
        bus_if.req_valid = 2'b11;
        bus_if.req_data  = 16'hB0A0;
        bus_if.req_last  = 2'b11;
        bus_if.tx_busy   = 1'b0;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_grant", s_grant, 0);
            check("rst_wr", s_wr, 0);
        end
        check("rst_ready", s_ready, 0);
        check("rst_lto", s_lto, 0);
        check("rst_tx_data", s_data, 0);

        // Single byte latency.
        do_reset();
        push_byte(0, 8'h41, 1'b1);
        apply_drive();
        tick();
        check("t2_grant_c0", s_grant, 2'b00);
        tick();
        check("t2_grant_c1", s_grant, 2'b01);
        check("t2_ready_c1", s_ready, 2'b01);
        tick();
        check("t2_wr_c2", s_wr, 1);
        check("t2_data_c2", s_data, 8'h41);
        tick();
        tick();
        tick();
        check("t2_grant_idle", s_grant, 2'b00);
        check("t2_count", log_data.size(), 1);

        // Fairness between two streams of one-byte messages.
        do_reset();
        busy_len = 2;
        push_byte(0, 8'hA0, 1'b1);
        push_byte(0, 8'hA0, 1'b1);
        push_byte(1, 8'hB0, 1'b1);
        push_byte(1, 8'hB0, 1'b1);
        apply_drive();
        wait_strobes(4, 200, "t3_strobes");
        exp_data  = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_data%0d", i), log_data[i], exp_data[i]);
            check($sformatf("t3_grant%0d", i), log_grant[i], exp_grant[i]);
        end

        // Lock: a multi-byte message is not interrupted.
        do_reset();
        busy_len = 3;
        push_byte(0, 8'h31, 1'b0);
        push_byte(0, 8'h32, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        push_byte(1, 8'h55, 1'b1);
        apply_drive();
        wait_strobes(4, 200, "t4_strobes");
        exp_data  = '{8'h31, 8'h32, 8'h33, 8'h55};
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_data%0d", i), log_data[i], exp_data[i]);
            check($sformatf("t4_grant%0d", i), log_grant[i], exp_grant[i]);
        end
        check("t4_no_lto", lto_seen, 0);

        // Timeout: owner stalls after a non-final byte.
        do_reset();
        push_byte(0, 8'h10, 1'b0);
        push_byte(1, 8'h77, 1'b1);
        apply_drive();
        wait_strobes(1, 20, "t5_first");
        k = 0;
        t_lto = -1;
        while (t_lto < 0 && k < 4 * LT) begin
            tick();
            if (s_lto === 1'b1) t_lto = s_cyc;
            k++;
        end
        // Owner re-enters OWN three cycles after the strobe, then idles LT cycles.
        check("t5_lto_time", t_lto - log_cyc[0], 3 + LT);
        check("t5_grant_at_lto", s_grant, 2'b00);
        tick();
        check("t5_lto_pulse", s_lto, 0);
        wait_strobes(2, 30, "t5_second");
        check("t5_data1", log_data[1], 8'h77);
        check("t5_grant1", log_grant[1], 2'b10);
        check("t5_lto_count", lto_seen, 1);

        // Backpressure from a long UART busy period.
        do_reset();
        busy_len = 50;
        push_byte(0, 8'h61, 1'b0);
        push_byte(0, 8'h62, 1'b1);
        apply_drive();
        wait_strobes(1, 20, "t6_first");
        ready_seen = 0;
        for (int i = 0; i < 50; i++) tick();
        check("t6_no_ready", ready_seen, 0);
        check("t6_no_strobe", log_data.size(), 1);
        wait_strobes(2, 20, "t6_second");
        check("t6_gap", log_cyc[1] - log_cyc[0], 53);
        check("t6_data1", log_data[1], 8'h62);

        // Reset while waiting in DRAIN drops the held byte.
        busy_len = 20;
        push_byte(0, 8'h70, 1'b1);
        apply_drive();
        wait_strobes(3, 80, "t6_third");
        for (int i = 0; i < 5; i++) tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        busy_cnt = 0;
        bus_if.tx_busy = 1'b0;
        n_before = log_data.size();
        for (int i = 0; i < 30; i++) tick();
        check("t6_no_rewrite", log_data.size(), n_before);
        check("t6_grant_idle", s_grant, 2'b00);

        // Randomized messages against a message-level round-robin reference.
        do_reset();
        rand_busy = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            m_data[r].delete();
            m_last[r].delete();
            for (int m = 0; m < int'($urandom_range(2, 5)); m++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom);
                    l = (j == len - 1);
                    push_byte(r, b, l);
                    m_data[r].push_back(b);
                    m_last[r].push_back(l);
                end
            end
        end
        exp_data.delete();
        exp_grant.delete();
        p = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            idx = 0;
            for (int kk = 0; kk < NUM_REQ; kk++) begin
                if (!found && m_data[(p + kk) % NUM_REQ].size() > 0) begin
                    found = 1'b1;
                    idx = (p + kk) % NUM_REQ;
                end
            end
            if (found) begin
                l = 1'b0;
                while (!l) begin
                    exp_data.push_back(m_data[idx].pop_front());
                    exp_grant.push_back(NUM_REQ'(1) << idx);
                    l = m_last[idx].pop_front();
                end
                p = (idx + 1) % NUM_REQ;
            end
        end
        total = exp_data.size();
        apply_drive();
        wait_strobes(total, 5000, "rnd_strobes");
        for (int i = 0; i < total; i++) begin
            check($sformatf("rnd_data%0d", i), log_data[i], exp_data[i]);
            check($sformatf("rnd_grant%0d", i), log_grant[i], exp_grant[i]);
        end
        check("rnd_no_lto", lto_seen, 0);

        check("invariants", inv_bad, 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
